// File: rtl/fa_32b.sv
// rtl/fa_32b.sv - 32-bit ripple-carry adder with registered sum and carry out

module fa_1b (
  input  logic a,
  input  logic b,
  input  logic c_i,
  output logic s,
  output logic c_o
);

  logic p;

  assign p   = a ^ b;
  assign s   = p ^ c_i;
  assign c_o = (a & b) | (c_i & p);

endmodule

module fa_32b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);

  logic [32:0] c;
  logic [31:0] sum;

  assign c[0] = c_in;

  // c[i+1] ripples from stage i into stage i+1; c[32] is the true unsigned carry
  for (genvar i = 0; i < 32; i++) begin : g_ripple
    fa_1b u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .c_i (c[i]),
      .s   (sum[i]),
      .c_o (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= '0;
      c_out <= 1'b0;
    end else begin
      s     <= sum;
      c_out <= c[32];
    end
  end

endmodule

// File: tb/tb_fa_32b.sv
// tb/tb_fa_32b.sv - scoreboard bench for fa_32b against a 33-bit arithmetic model

module tb_fa_32b;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic [31:0] s;
  logic        c_out;

  typedef struct {
    logic [32:0] exp;
    int          due;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  fa_32b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .s     (s),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual {c_out,s}=%h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  // Drive at a falling edge; the result is due after the next rising edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic [32:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    a    = x;
    b    = y;
    c_in = ci;
    e.exp  = exp;
    e.due  = cyc + 1;
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: compare every result that has become visible.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk(e.name, {c_out, s}, e.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        ci;
    logic [32:0] exp;
    string       name;
  } vec_t;

  vec_t dir[6];

  initial begin
    dir[0] = '{32'hFFFF699A, 32'h00014000, 1'b0, 33'h1_0000A99A, "fix_neg_pos"};
    dir[1] = '{32'h00028F5C, 32'h00014000, 1'b0, 33'h0_0003CF5C, "fix_pos"};
    dir[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000, "wrap"};
    dir[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h0_80000000, "carry_msb"};
    dir[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF, "max_in"};
    dir[5] = '{32'h00000000, 32'h00000000, 1'b1, 33'h0_00000001, "cin_only"};

    rst_n = 1'b0;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    c_in = 1'b1;
    #1;
    chk("reset_t0", {c_out, s}, 33'd0);

    // Inputs toggle while reset is held; outputs stay zero across clock edges.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      c_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("reset_hold", {c_out, s}, 33'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd0, 32'd0, 1'b0, 33'd0, "post_reset_zero");

    foreach (dir[i]) issue(dir[i].x, dir[i].y, dir[i].ci, dir[i].exp, dir[i].name);

    // Back-to-back random vectors; some cycles wiggle the inputs between edges.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] x, y;
      logic ci;
      x  = $urandom;
      y  = $urandom;
      ci = 1'($urandom_range(0, 1));
      if (i % 16 == 3) x = 32'hFFFFFFFF - y;
      issue(x, y, ci, model(x, y, ci), "random");
      if (i % 7 == 0) begin
        @(posedge clk);
        #2;
        a = $urandom;
        b = $urandom;
        c_in = ~c_in;
      end
    end

    // Reset mid-stream: the just-loaded result is discarded immediately.
    issue(32'h12345678, 32'h9ABCDEF0, 1'b1, 33'd0, "unused");
    @(posedge clk);
    #2;
    void'(q.pop_back());
    rst_n = 1'b0;
    #1;
    chk("reset_midstream", {c_out, s}, 33'd0);
    @(posedge clk);
    #1;
    chk("reset_midstream_hold", {c_out, s}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000, "after_reset");
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 33'h0_00010000, "after_reset_2");

    repeat (3) @(negedge clk);
    #2;
    chk("scoreboard_drained", 33'(q.size()), 33'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fa_32b.md
FA_32B -- requirements
Module: fa_32b

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk and rst_n are its only timing/control ports.
REQ-002 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-004 Port a, input, 32 bits: addend A, an unsigned 32-bit vector (also valid as two's-complement or sign/Q17.14 fixed point).
REQ-005 Port b, input, 32 bits: addend B, same encoding as a.
REQ-006 Port c_in, input, 1 bit: carry into bit 0.
REQ-007 Port s, output, 32 bits: registered sum bits [31:0].
REQ-008 Port c_out, output, 1 bit: registered carry out of bit 31.
REQ-009 The block SHALL have no parameters; the width is fixed at 32.

Function
REQ-010 At each rising clk edge with rst_n high, {c_out, s} SHALL be loaded with the 33-bit result of a + b + c_in sampled at that edge.
REQ-011 The arithmetic SHALL be unsigned modulo 2^33; c_out is the true carry out of bit 31, not a signed-overflow flag.
REQ-012 The latency SHALL be exactly one clock: the result for inputs present at edge N is visible on s/c_out after edge N and holds until edge N+1.
REQ-013 There SHALL be no handshake; a new operation is accepted every cycle, giving a throughput of 1 operation per clock.
REQ-014 The combinational datapath SHALL be a 32-stage ripple chain of 1-bit full adders.
REQ-015 In each 1-bit full adder, s_i = a_i XOR b_i XOR c_i and c_(i+1) = a_i·b_i + c_i·(a_i XOR b_i).
REQ-016 The chain SHALL have c_0 = c_in and c_out = c_32.
REQ-017 The combinational path SHALL settle within one clock period at the target frequency.
REQ-018 Fixed-point data SHALL pass through unchanged: there is no saturation, rounding or sign handling; the interpretation belongs to the user.
REQ-019 Wrap-around: 0xFFFFFFFF + 0x00000000 + 1 SHALL give s = 0x00000000 and c_out = 1.
REQ-020 Maximum input: 0xFFFFFFFF + 0xFFFFFFFF + 1 SHALL give s = 0xFFFFFFFF and c_out = 1.
REQ-021 Inputs that change between clock edges SHALL have no effect on the outputs until the next rising edge.
REQ-022 X or Z on an input at a capturing edge is undefined usage; there is no requirement on the resulting output.

Reset
REQ-023 While rst_n is low, s SHALL be 0x00000000 and c_out SHALL be 0, asynchronously and without waiting for clk.
REQ-024 If reset asserts in the middle of operation, the pending result SHALL be discarded immediately and the outputs forced to 0.
REQ-025 Reset deassertion SHALL be clean: the first rising edge with rst_n high loads a + b + c_in normally.
REQ-026 If an edge and a reset release coincide, the reset SHALL win for that edge.
REQ-027 The block SHALL hold no state other than the 33 output register bits.

Verification
REQ-028 Reset: hold rst_n low and toggle the inputs -> s = 0x00000000 and c_out = 0 throughout; after release, a = b = 0 and c_in = 0 -> s = 0, c_out = 0.
REQ-029 Negative plus positive fixed point: a = 0xFFFF699A (-2.35), b = 0x00014000 (5), c_in = 0 -> s = 0x0000A99A (2.65) and c_out = 1, one clock later.
REQ-030 Positive fixed point: a = 0x00028F5C (10.24), b = 0x00014000 (5), c_in = 0 -> s = 0x0003CF5C (15.24) and c_out = 0.
REQ-031 Carry propagation: a = 0xFFFFFFFF, b = 0, c_in = 1 -> s = 0x00000000 and c_out = 1.
REQ-032 Carry propagation: a = 0x7FFFFFFF, b = 1, c_in = 0 -> s = 0x80000000 and c_out = 0.
REQ-033 Back-to-back inputs changing every cycle -> each result appears exactly one cycle later.
REQ-034 Asserting rst_n mid-stream -> outputs go to 0 immediately, before the next clock edge.
REQ-035 Random regression: at least 10,000 random (a, b, c_in) vectors compared against a 33-bit reference sum delayed by one cycle -> zero mismatches.
